// File: rtl/sd_defs_pkg.sv
// ============================================================================
// Module   : sd_defs (package)
// Purpose  : Shared SDRAM command encodings and init-sequencer state codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_defs;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_PRE  = 3'b010;
  localparam logic [2:0] CMD_AREF = 3'b001;
  localparam logic [2:0] CMD_MRS  = 3'b000;

  localparam int A10_IDX = 10;

  localparam logic [3:0] ST_WAIT_LOCK = 4'd0;
  localparam logic [3:0] ST_PWR       = 4'd1;
  localparam logic [3:0] ST_PRE       = 4'd2;
  localparam logic [3:0] ST_TRP       = 4'd3;
  localparam logic [3:0] ST_AREF      = 4'd4;
  localparam logic [3:0] ST_TRFC      = 4'd5;
  localparam logic [3:0] ST_MRS       = 4'd6;
  localparam logic [3:0] ST_TMRD      = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  typedef enum logic [3:0] {
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_PWR       = ST_PWR,
    S_PRE       = ST_PRE,
    S_TRP       = ST_TRP,
    S_AREF      = ST_AREF,
    S_TRFC      = ST_TRFC,
    S_MRS       = ST_MRS,
    S_TMRD      = ST_TMRD,
    S_DONE      = ST_DONE
  } state_t;

  // Mode register: reserved bits zero, sequential burst (A3=0), A6 unused.
  function automatic logic [10:0] mrs_addr(input logic [1:0] cl, input logic [2:0] bl);
    return {4'b0000, 1'b0, cl, 1'b0, bl};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_init_seq.sv
// ============================================================================
// Module   : sd_init_seq
// Purpose  : SDRAM power-up sequencer (power wait, PRECHARGE ALL, N x AUTO
//            REFRESH, LOAD MODE) driving the pad command bus until init_done.
//            Optional macro SD_INIT_CKE_CTRL_EN holds CKE low until CKE_LEAD
//            cycles before the end of the power wait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_init_seq
  import sd_defs::*;
#(
  parameter logic [15:0] PWR_WAIT = 16'd20000,
  parameter logic [3:0]  TRP_CYC  = 4'd2,
  parameter logic [3:0]  TRFC_CYC = 4'd7,
  parameter logic [3:0]  NUM_AREF = 4'd8,
  parameter logic [3:0]  TMRD_CYC = 4'd2
`ifdef SD_INIT_CKE_CTRL_EN
  , parameter logic [15:0] CKE_LEAD = 16'd16
`endif
) (
  input  logic        Clk_i,
  input  logic        Reset,
  input  logic        Locked,
  input  logic [1:0]  mode_cl,
  input  logic [2:0]  mode_bl,
  output logic        sd_ras_o,
  output logic        sd_cas_o,
  output logic        sd_we_o,
  output logic        sd_ba_o,
  output logic [10:0] sd_add_o,
  output logic        sd_cke_o,
  output logic        init_done
);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_rcnt, w_rcnt_nxt;
  logic [2:0]  r_cmd, w_cmd_nxt;
  logic [10:0] r_add, w_add_nxt;
  logic        r_ba;
  logic        r_cke, w_cke_nxt;
  logic        r_done, w_done_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    w_cmd_nxt   = CMD_NOP;
    w_add_nxt   = '0;
    w_done_nxt  = 1'b0;
    // Losing lock abandons any partial sequence; it restarts from scratch.
    if (!Locked) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          w_cnt_nxt   = PWR_WAIT - 16'd1;
          w_state_nxt = S_PWR;
        end
        S_PWR: begin
          if (r_cnt == 16'd0) w_state_nxt = S_PRE;
          else                w_cnt_nxt   = r_cnt - 16'd1;
        end
        S_PRE: begin
          w_cmd_nxt          = CMD_PRE;
          w_add_nxt[A10_IDX] = 1'b1;
          w_cnt_nxt          = {12'd0, TRP_CYC - 4'd1};
          w_state_nxt        = S_TRP;
        end
        S_TRP: begin
          if (r_cnt == 16'd0) begin
            w_rcnt_nxt  = NUM_AREF - 4'd1;
            w_state_nxt = S_AREF;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
        S_AREF: begin
          w_cmd_nxt   = CMD_AREF;
          w_cnt_nxt   = {12'd0, TRFC_CYC - 4'd1};
          w_state_nxt = S_TRFC;
        end
        S_TRFC: begin
          if (r_cnt != 16'd0) begin
            w_cnt_nxt = r_cnt - 16'd1;
          end else if (r_rcnt == 4'd0) begin
            w_state_nxt = S_MRS;
          end else begin
            w_rcnt_nxt  = r_rcnt - 4'd1;
            w_state_nxt = S_AREF;
          end
        end
        S_MRS: begin
          w_cmd_nxt   = CMD_MRS;
          w_add_nxt   = mrs_addr(mode_cl, mode_bl);
          w_cnt_nxt   = {12'd0, TMRD_CYC - 4'd1};
          w_state_nxt = S_TMRD;
        end
        S_TMRD: begin
          if (r_cnt == 16'd0) w_state_nxt = S_DONE;
          else                w_cnt_nxt   = r_cnt - 16'd1;
        end
        S_DONE:  w_done_nxt  = 1'b1;
        default: w_state_nxt = S_WAIT_LOCK;
      endcase
    end
  end

`ifdef SD_INIT_CKE_CTRL_EN
  localparam logic c_cke_rst = 1'b0;
  // CKE follows the upcoming state so it rises on the edge cnt reaches CKE_LEAD-1.
  assign w_cke_nxt = (w_state_nxt != S_WAIT_LOCK) &&
                     ((w_state_nxt != S_PWR) || (w_cnt_nxt < CKE_LEAD));
`else
  localparam logic c_cke_rst = 1'b1;
  assign w_cke_nxt = 1'b1;
`endif

  always_ff @(posedge Clk_i or posedge Reset) begin
    if (Reset) begin
      r_state <= S_WAIT_LOCK;
      r_cnt   <= '0;
      r_rcnt  <= '0;
      r_cmd   <= CMD_NOP;
      r_add   <= '0;
      r_ba    <= 1'b0;
      r_cke   <= c_cke_rst;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_cmd   <= w_cmd_nxt;
      r_add   <= w_add_nxt;
      r_ba    <= 1'b0;
      r_cke   <= w_cke_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign {sd_ras_o, sd_cas_o, sd_we_o} = r_cmd;
  assign sd_ba_o   = r_ba;
  assign sd_add_o  = r_add;
  assign sd_cke_o  = r_cke;
  assign init_done = r_done;

endmodule

`default_nettype wire
